// File: rtl/reg_issue_pkg.sv
// Shared definitions for the register-file issue stage: opcodes, instruction
// field positions and the issue FSM state encoding.
package reg_issue_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_NOP  = 4'h0;
  localparam logic [FIELD_W-1:0] OP_ADD  = 4'h1;
  localparam logic [FIELD_W-1:0] OP_HALT = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  function automatic logic [FIELD_W-1:0] instr_field(input logic [INSTR_W-1:0] instr,
                                                      input int lsb);
    return instr[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/reg_issue_unit_if.sv
// Instruction word valid/ready handshake into the issue unit.
interface reg_issue_unit_if;
  import reg_issue_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);

endinterface

// File: rtl/issue_fifo.sv
// Synchronous FIFO with registered occupancy; head word is read combinationally.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/reg_issue_unit.sv
// Instruction buffer and issue stage feeding the 16x16 register file.
// Optional result capture path enabled by defining RESULT_CAPTURE_EN.
module reg_issue_unit
  import reg_issue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_issue_unit_if.slave        bus,
  input  logic                   resume,
  output logic                   halted,
  output logic [ADDR_W-1:0]      rf_readaddr1,
  output logic [ADDR_W-1:0]      rf_readaddr2,
  output logic [ADDR_W-1:0]      rf_writeaddr,
  output logic                   rf_w_en,
  input  logic [DATA_W-1:0]      rf_writedata,
  output logic [CNT_W-1:0]       issue_count,
`ifdef RESULT_CAPTURE_EN
  output logic [DATA_W-1:0]      result,
  output logic                   result_valid,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  raddr1_q, raddr1_d;
  logic [ADDR_W-1:0]  raddr2_q, raddr2_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic               w_en_q, w_en_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               push, pop, full, empty;
  logic [INSTR_W-1:0] head;

  // Ready comes only from registered occupancy, never from the same-cycle pop.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.in_instr),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    waddr_d  = waddr_q;
    w_en_d   = 1'b0;
    count_d  = count_q;
    pop      = 1'b0;
    case (state_q)
      RUN: begin
        if (!empty) begin
          pop = 1'b1;
          case (instr_field(head, OPC_LSB))
            OP_ADD: begin
              raddr1_d = ADDR_W'(instr_field(head, RS1_LSB));
              raddr2_d = ADDR_W'(instr_field(head, RS2_LSB));
              waddr_d  = ADDR_W'(instr_field(head, RD_LSB));
              w_en_d   = 1'b1;
              count_d  = count_q + CNT_W'(1);
            end
            OP_HALT: state_d = HALTED;
            default: ;
          endcase
        end
      end
      HALTED: begin
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      raddr1_q <= '0;
      raddr2_q <= '0;
      waddr_q  <= '0;
      w_en_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      waddr_q  <= waddr_d;
      w_en_q   <= w_en_d;
      count_q  <= count_d;
    end
  end

  assign halted       = (state_q == HALTED);
  assign rf_readaddr1 = raddr1_q;
  assign rf_readaddr2 = raddr2_q;
  assign rf_writeaddr = waddr_q;
  assign rf_w_en      = w_en_q;
  assign issue_count  = count_q;

`ifdef RESULT_CAPTURE_EN
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;

  // rf_writedata is the sum being written during the rf_w_en cycle.
  always_comb begin
    result_d       = result_q;
    result_valid_d = w_en_q;
    if (w_en_q) result_d = rf_writedata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
`else
  logic unused_writedata;
  assign unused_writedata = ^rf_writedata;
`endif

endmodule

// File: tb/tb_reg_issue_unit.sv
// Scoreboard bench for reg_issue_unit with a behavioural register file (mem[i]=i).
module tb_reg_issue_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa;
    logic [15:0] cnt;
    logic [15:0] sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        resume;
  logic        halted;
  logic [3:0]  rf_readaddr1, rf_readaddr2, rf_writeaddr;
  logic        rf_w_en;
  logic [15:0] rf_writedata;
  logic [15:0] issue_count;
  logic [2:0]  fifo_level;
`ifdef RESULT_CAPTURE_EN
  logic [15:0] result;
  logic        result_valid;
  logic        res_pend = 1'b0;
  logic [15:0] res_exp  = '0;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  reg_issue_unit_if bus();

  reg_issue_unit #(
    .DEPTH(DEPTH), .ADDR_W(4), .DATA_W(16), .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .resume       (resume),
    .halted       (halted),
    .rf_readaddr1 (rf_readaddr1),
    .rf_readaddr2 (rf_readaddr2),
    .rf_writeaddr (rf_writeaddr),
    .rf_w_en      (rf_w_en),
    .rf_writedata (rf_writedata),
    .issue_count  (issue_count),
`ifdef RESULT_CAPTURE_EN
    .result       (result),
    .result_valid (result_valid),
`endif
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write at the edge, adder on the write port.
  logic [15:0] rf_mem [16];
  logic        rf_init_done = 1'b0;
  assign rf_writedata = rf_mem[rf_readaddr1] + rf_mem[rf_readaddr2];

  always @(posedge clk) begin
    if (!rf_init_done) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 16'(i);
      rf_init_done <= 1'b1;
    end else if (rf_w_en) begin
      rf_mem[rf_writeaddr] <= rf_writedata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_add(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                            input logic [15:0] cnt, input logic [15:0] sum);
    exp_t e;
    e.ra1 = ra1; e.ra2 = ra2; e.wa = wa; e.cnt = cnt; e.sum = sum;
    exp_q.push_back(e);
  endtask

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic push(input logic [15:0] w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=in_ready_low expected=accept of %0h", w);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every rf_w_en pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
`ifdef RESULT_CAPTURE_EN
      res_pend <= 1'b0;
      if (res_pend) begin
        chk("result_valid", {31'd0, result_valid}, 32'd1);
        chk("result", {16'd0, result}, {16'd0, res_exp});
      end else if (result_valid) begin
        chk("result_valid_spurious", {31'd0, result_valid}, 32'd0);
      end
`endif
      if (rf_w_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wen actual=waddr %0h expected=no pulse", rf_writeaddr);
        end else begin
          e = exp_q.pop_front();
          chk("raddr1", {28'd0, rf_readaddr1}, {28'd0, e.ra1});
          chk("raddr2", {28'd0, rf_readaddr2}, {28'd0, e.ra2});
          chk("waddr", {28'd0, rf_writeaddr}, {28'd0, e.wa});
          chk("issue_count", {16'd0, issue_count}, {16'd0, e.cnt});
          chk("writedata", {16'd0, rf_writedata}, {16'd0, e.sum});
`ifdef RESULT_CAPTURE_EN
          res_pend <= 1'b1;
          res_exp  <= e.sum;
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    resume       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_wen", {31'd0, rf_w_en}, 32'd0);
    chk("rst_waddr", {28'd0, rf_writeaddr}, 32'd0);
    chk("rst_count", {16'd0, issue_count}, 32'd0);

    // Single ADD r5 = r1 + r2
    expect_add(4'h1, 4'h2, 4'h5, 16'd1, 16'd3);
    push(16'h1512);
    chk("lat_cycle1_wen", {31'd0, rf_w_en}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2_wen", {31'd0, rf_w_en}, 32'd1);
    repeat (3) @(negedge clk);

    // Back-to-back with read-after-write: r6 = r5 + r5 = 6
    expect_add(4'h1, 4'h2, 4'h5, 16'd2, 16'd3);
    expect_add(4'h5, 4'h5, 4'h6, 16'd3, 16'd6);
    push(16'h1512);
    push(16'h1655);
    chk("b2b_first_wen", {31'd0, rf_w_en}, 32'd1);
    chk("b2b_first_waddr", {28'd0, rf_writeaddr}, 32'd5);
    @(negedge clk);
    chk("b2b_second_wen", {31'd0, rf_w_en}, 32'd1);
    chk("b2b_second_waddr", {28'd0, rf_writeaddr}, 32'd6);
    repeat (3) @(negedge clk);

    // NOP and undefined opcode are consumed silently
    push(16'h0123);
    push(16'h7123);
    repeat (4) @(negedge clk);
    chk("nop_count", {16'd0, issue_count}, 32'd3);
    chk("nop_wen", {31'd0, rf_w_en}, 32'd0);
    chk("nop_waddr_hold", {28'd0, rf_writeaddr}, 32'd6);
    chk("nop_raddr1_hold", {28'd0, rf_readaddr1}, 32'd5);
    chk("nop_level", {29'd0, fifo_level}, 32'd0);

    // HALT then fill the FIFO
    expect_add(4'h1, 4'h2, 4'h7, 16'd4, 16'd3);
    expect_add(4'h7, 4'h7, 4'h8, 16'd5, 16'd6);
    expect_add(4'h8, 4'h8, 4'h9, 16'd6, 16'd12);
    expect_add(4'h9, 4'h9, 4'hA, 16'd7, 16'd24);
    push(16'hF000);
    push(16'h1712);
    chk("fill1_level", {29'd0, fifo_level}, 32'd1);
    chk("fill1_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    push(16'h1877);
    chk("fill2_level", {29'd0, fifo_level}, 32'd2);
    push(16'h1988);
    chk("fill3_level", {29'd0, fifo_level}, 32'd3);
    chk("fill3_ready", {31'd0, bus.in_ready}, 32'd1);
    push(16'h1A99);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h1FFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("extra_level", {29'd0, fifo_level}, 32'd4);
      chk("extra_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("extra_halted", {31'd0, halted}, 32'd1);
    end
    bus.in_valid = 1'b0;

    // Resume drains four ADDs on consecutive cycles
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_level", {29'd0, fifo_level}, 32'd4);
    chk("resume_wen", {31'd0, rf_w_en}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_wen", {31'd0, rf_w_en}, 32'd1);
      chk("drain_waddr", {28'd0, rf_writeaddr}, 32'(7 + k));
      chk("drain_level", {29'd0, fifo_level}, 32'(3 - k));
    end
    @(negedge clk);
    chk("drain_done_wen", {31'd0, rf_w_en}, 32'd0);
    repeat (2) @(negedge clk);

    // Reset with three words buffered behind a HALT
    push(16'hF000);
    push(16'h1123);
    push(16'h1123);
    push(16'h1123);
    chk("prerst_level", {29'd0, fifo_level}, 32'd3);
    chk("prerst_halted", {31'd0, halted}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_level", {29'd0, fifo_level}, 32'd0);
    chk("midrst_wen", {31'd0, rf_w_en}, 32'd0);
    chk("midrst_count", {16'd0, issue_count}, 32'd0);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    chk("midrst_ready", {31'd0, bus.in_ready}, 32'd1);

    // Counter restarts after reset
    expect_add(4'h1, 4'h2, 4'h5, 16'd1, 16'd3);
    push(16'h1512);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
